block_scanout: RTL



---
 rtl/gpu_scan_pkg.sv | 27 ++
 rtl/scan_seg_fifo.sv | 64 ++++++
 rtl/block_scanout.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_scan_pkg.sv
// Shared constants, FSM state type and address packing for the block scanout path.
package gpu_scan_pkg;

  localparam int unsigned BLOCK_W = 16;
  localparam int unsigned PLANE_W = 256;
  localparam int unsigned SEG_W   = 48;
  localparam int unsigned ENTRY_W = SEG_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } scan_state_e;

  // Per-request tag travelling alongside the memory read latency.
  typedef struct packed {
    logic       vld;
    logic [3:0] row;
    logic       sof;
    logic       eol;
  } req_tag_t;

  function automatic logic [12:0] pack_addr(input logic [6:0] bx, input logic [5:0] by);
    return {bx, by};
  endfunction

endpackage

// File: rtl/scan_seg_fifo.sv
// Two-entry synchronous FIFO holding {sof, eol, 48-bit row segment} entries.
module scan_seg_fifo
  import gpu_scan_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               do_wr, do_rd;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/block_scanout.sv
// Raster-order block-memory reader feeding a 16-pixel row serialiser.
// Defining SCANOUT_UNDERRUN_EN adds the underrun_cnt starvation counter port.
module block_scanout
  import gpu_scan_pkg::*;
#(
  parameter int unsigned BLOCKS_X   = 72,
  parameter int unsigned BLOCKS_Y   = 54,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  output logic [12:0]        block_address_b,
  input  logic [PLANE_W-1:0] qreds_b,
  input  logic [PLANE_W-1:0] qgreens_b,
  input  logic [PLANE_W-1:0] qblues_b,
  output logic [2:0]         pix_rgb,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               busy,
  output logic               frame_done
`ifdef SCANOUT_UNDERRUN_EN
  ,
  output logic [15:0]        underrun_cnt
`endif
);

  localparam logic [6:0] BX_LAST   = 7'(BLOCKS_X - 1);
  localparam logic [9:0] LINE_LAST = 10'(BLOCK_W * BLOCKS_Y - 1);

  scan_state_e        state_q, state_d;
  logic [6:0]         bx_q, bx_d;
  logic [9:0]         line_q, line_d;
  logic [12:0]        addr_q, addr_d;
  req_tag_t           pipe_q [RD_LATENCY];
  req_tag_t           pipe_d [RD_LATENCY];
  logic [BLOCK_W-1:0] r_sh_q, r_sh_d, g_sh_q, g_sh_d, b_sh_q, b_sh_d;
  logic [3:0]         idx_q, idx_d;
  logic               seg_vld_q, seg_vld_d;
  logic               seg_sof_q, seg_sof_d;
  logic               seg_eol_q, seg_eol_d;
  logic               done_q, done_d;

  logic [2:0]         inflight;
  logic [1:0]         fifo_cnt;
  logic               fifo_full, fifo_empty, fifo_rd;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  req_tag_t           cap_tag;
  logic               start_go, accept, last_px, req;

  assign cap_tag    = pipe_q[RD_LATENCY-1];
  assign fifo_wdata = {cap_tag.sof, cap_tag.eol,
                       qreds_b[{cap_tag.row, 4'h0} +: BLOCK_W],
                       qgreens_b[{cap_tag.row, 4'h0} +: BLOCK_W],
                       qblues_b[{cap_tag.row, 4'h0} +: BLOCK_W]};

  scan_seg_fifo u_fifo (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (cap_tag.vld),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign block_address_b = addr_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = done_q;
  assign pix_valid       = seg_vld_q;
  assign pix_rgb         = {r_sh_q[0], g_sh_q[0], b_sh_q[0]};
  assign pix_sof         = seg_vld_q && seg_sof_q && (idx_q == 4'd0);
  assign pix_eol         = seg_vld_q && seg_eol_q && (idx_q == 4'd15);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, pipe_q[i].vld};
    end
  end

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    line_d    = line_q;
    addr_d    = addr_q;
    r_sh_d    = r_sh_q;
    g_sh_d    = g_sh_q;
    b_sh_d    = b_sh_q;
    idx_d     = idx_q;
    seg_vld_d = seg_vld_q;
    seg_sof_d = seg_sof_q;
    seg_eol_d = seg_eol_q;
    done_d    = 1'b0;
    pipe_d[0] = '0;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // A start landing on the frame_done cycle must not retrigger.
    start_go = (state_q == IDLE) && start && !done_q;
    accept   = seg_vld_q && pix_ready;
    last_px  = accept && (idx_q == 4'd15);
    fifo_rd  = !fifo_empty && (!seg_vld_q || last_px);
    req      = (state_q == FETCH) && !fifo_full && (({1'b0, fifo_cnt} + inflight) < 3'd2);

    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = FETCH;
          bx_d    = '0;
          line_d  = '0;
        end
      end
      FETCH: begin
        if (req) begin
          addr_d    = pack_addr(bx_q, line_q[9:4]);
          pipe_d[0] = '{vld: 1'b1, row: line_q[3:0],
                        sof: (bx_q == '0) && (line_q == '0),
                        eol: (bx_q == BX_LAST)};
          if (bx_q == BX_LAST) begin
            bx_d = '0;
            if (line_q == LINE_LAST) begin
              line_d  = '0;
              state_d = DRAIN;
            end else begin
              line_d = line_q + 10'd1;
            end
          end else begin
            bx_d = bx_q + 7'd1;
          end
        end
      end
      DRAIN: begin
        if (last_px && fifo_empty && (inflight == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_rd) begin
      {seg_sof_d, seg_eol_d, r_sh_d, g_sh_d, b_sh_d} = fifo_rdata;
      idx_d     = '0;
      seg_vld_d = 1'b1;
    end else if (accept) begin
      r_sh_d = r_sh_q >> 1;
      g_sh_d = g_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      idx_d  = idx_q + 4'd1;
      if (idx_q == 4'd15) begin
        seg_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      bx_q      <= '0;
      line_q    <= '0;
      addr_q    <= '0;
      r_sh_q    <= '0;
      g_sh_q    <= '0;
      b_sh_q    <= '0;
      idx_q     <= '0;
      seg_vld_q <= 1'b0;
      seg_sof_q <= 1'b0;
      seg_eol_q <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      r_sh_q    <= r_sh_d;
      g_sh_q    <= g_sh_d;
      b_sh_q    <= b_sh_d;
      idx_q     <= idx_d;
      seg_vld_q <= seg_vld_d;
      seg_sof_q <= seg_sof_d;
      seg_eol_q <= seg_eol_d;
      done_q    <= done_d;
      pipe_q    <= pipe_d;
    end
  end

`ifdef SCANOUT_UNDERRUN_EN
  logic        first_acc_q, first_acc_d;
  logic [15:0] urun_q, urun_d;

  always_comb begin
    first_acc_d = first_acc_q;
    urun_d      = urun_q;
    if (start_go) begin
      first_acc_d = 1'b0;
      urun_d      = '0;
    end else begin
      if (accept) begin
        first_acc_d = 1'b1;
      end
      if (busy && pix_ready && !pix_valid && first_acc_q && (urun_q != '1)) begin
        urun_d = urun_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      first_acc_q <= 1'b0;
      urun_q      <= '0;
    end else begin
      first_acc_q <= first_acc_d;
      urun_q      <= urun_d;
    end
  end

  assign underrun_cnt = urun_q;
`endif

endmodule
